// File: rtl/lapido_alu.sv
// lapido_alu: integer ALU for the core_lapido execute stage.
// One operation per clock, result and status flags registered with a
// single cycle of latency. alu_res carries a carry/borrow bit above the
// DATA_W-bit value; flags summarise the value for branch/flag logic.
module lapido_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_rs,
  input  logic [DATA_W-1:0] data_rt,
  input  logic [5:0]        alu_funct,
  output logic [DATA_W:0]   alu_res,
  output logic [4:0]        flags
);

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_PASSB = 6'h0F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic              slt_w;
  logic              sltu_w;
  logic [DATA_W:0]   res_next;
  logic              ov_next;
  logic [DATA_W-1:0] r_val;
  logic              zero_w;
  logic [4:0]        flags_next;

  // Zero-extended operands make bit DATA_W the carry for add and the borrow
  // for subtract (borrow is set exactly when A < B unsigned).
  assign shamt  = data_rt[SH_W-1:0];
  assign sum_w  = {1'b0, data_rs} + {1'b0, data_rt};
  assign diff_w = {1'b0, data_rs} - {1'b0, data_rt};
  assign slt_w  = $signed(data_rs) < $signed(data_rt);
  assign sltu_w = data_rs < data_rt;

  // Operation select; unknown codes fall through to a zero result.
  always_comb begin
    res_next = '0;
    ov_next  = 1'b0;
    case (alu_funct)
      FN_ADD: begin
        res_next = sum_w;
        ov_next  = (data_rs[MSB] == data_rt[MSB]) && (sum_w[MSB] != data_rs[MSB]);
      end
      FN_SUB: begin
        res_next = diff_w;
        ov_next  = (data_rs[MSB] != data_rt[MSB]) && (diff_w[MSB] != data_rs[MSB]);
      end
      FN_AND:   res_next = {1'b0, data_rs & data_rt};
      FN_OR:    res_next = {1'b0, data_rs | data_rt};
      FN_XOR:   res_next = {1'b0, data_rs ^ data_rt};
      FN_NOR:   res_next = {1'b0, ~(data_rs | data_rt)};
      FN_SLT:   res_next = {{DATA_W{1'b0}}, slt_w};
      FN_SLTU:  res_next = {{DATA_W{1'b0}}, sltu_w};
      FN_SLL:   res_next = {1'b0, data_rs << shamt};
      FN_SRL:   res_next = {1'b0, data_rs >> shamt};
      FN_SRA:   res_next = {1'b0, $unsigned($signed(data_rs) >>> shamt)};
      FN_PASSB: res_next = {1'b0, data_rt};
      default:  res_next = '0;
    endcase
  end

  // Status flags derive from the value bits only; a zero value for an
  // unknown code naturally yields ZERO=1 and LEZ=1 with the rest clear.
  assign r_val      = res_next[DATA_W-1:0];
  assign zero_w     = ~|r_val;
  assign flags_next = {ov_next, r_val[MSB], zero_w, ~zero_w, r_val[MSB] | zero_w};

  // Output register; reset clears it immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_res <= '0;
      flags   <= '0;
    end else begin
      alu_res <= res_next;
      flags   <= flags_next;
    end
  end

endmodule

// File: tb/tb_lapido_alu.sv
// Directed-vector bench for lapido_alu: a table of hand-computed results
// applied one per clock, plus hand-written reset sequences.
module tb_lapido_alu;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_PASSB = 6'h0F;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // flags: {OV, NEG, ZERO, TRUE, LEZ}
  localparam logic [4:0] F_POS  = 5'b00010;
  localparam logic [4:0] F_NEG  = 5'b01011;
  localparam logic [4:0] F_ZERO = 5'b00101;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] res;
    logic [4:0]  flg;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_rs;
  logic [31:0] data_rt;
  logic [5:0]  alu_funct;
  logic [32:0] alu_res;
  logic [4:0]  flags;

  int n_vec;
  int n_err;
  vec_t vec_q[$];

  lapido_alu #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_rs   (data_rs),
    .data_rt   (data_rt),
    .alu_funct (alu_funct),
    .alu_res   (alu_res),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] exp_res, input logic [4:0] exp_flg);
    n_vec++;
    if (alu_res !== exp_res || flags !== exp_flg) begin
      n_err++;
      $display("FAIL %s: res=%h flags=%b, expected res=%h flags=%b", name, alu_res, flags, exp_res, exp_flg);
    end else begin
      $display("ok   %s: res=%h flags=%b", name, alu_res, flags);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    alu_funct = f;
    data_rs   = a;
    data_rt   = b;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    vec_q.push_back('{FN_ADD,  32'h00000002, 32'h00000001, 33'h0_00000003, F_POS});
    vec_q.push_back('{FN_SUB,  32'h00000002, 32'h00000001, 33'h0_00000001, F_POS});
    vec_q.push_back('{FN_SUB,  32'h00000001, 32'h00000002, 33'h1_FFFFFFFF, F_NEG});
    vec_q.push_back('{FN_ADD,  32'h7FFFFFFF, 32'h00000001, 33'h0_80000000, 5'b11011});
    vec_q.push_back('{FN_ADD,  32'hFFFFFFFF, 32'h00000001, 33'h1_00000000, F_ZERO});
    vec_q.push_back('{FN_ADD,  32'h80000000, 32'h80000000, 33'h1_00000000, 5'b10101});
    vec_q.push_back('{FN_SUB,  32'h80000000, 32'h00000001, 33'h0_7FFFFFFF, 5'b10010});
    vec_q.push_back('{FN_SUB,  32'h00000005, 32'h00000005, 33'h0_00000000, F_ZERO});
    vec_q.push_back('{FN_SLT,  32'hFFFFFFFF, 32'h00000001, 33'h0_00000001, F_POS});
    vec_q.push_back('{FN_SLTU, 32'hFFFFFFFF, 32'h00000001, 33'h0_00000000, F_ZERO});
    vec_q.push_back('{FN_SLT,  32'h00000001, 32'hFFFFFFFF, 33'h0_00000000, F_ZERO});
    vec_q.push_back('{FN_SLTU, 32'h00000001, 32'hFFFFFFFF, 33'h0_00000001, F_POS});
    vec_q.push_back('{FN_SLT,  32'h80000000, 32'h7FFFFFFF, 33'h0_00000001, F_POS});
    vec_q.push_back('{FN_SRA,  32'h80000000, 32'h00000004, 33'h0_F8000000, F_NEG});
    vec_q.push_back('{FN_SRL,  32'h80000000, 32'h00000004, 33'h0_08000000, F_POS});
    vec_q.push_back('{FN_SRA,  32'h7FFFFFF0, 32'h00000004, 33'h0_07FFFFFF, F_POS});
    vec_q.push_back('{FN_SRA,  32'h80000000, 32'h0000001F, 33'h0_FFFFFFFF, F_NEG});
    vec_q.push_back('{FN_SRL,  32'h80000000, 32'h0000001F, 33'h0_00000001, F_POS});
    vec_q.push_back('{FN_SRL,  32'h12345678, 32'h00000000, 33'h0_12345678, F_POS});
    vec_q.push_back('{FN_SLL,  32'h00000001, 32'h0000001F, 33'h0_80000000, F_NEG});
    vec_q.push_back('{FN_SLL,  32'h00000003, 32'h00000025, 33'h0_00000060, F_POS});
    vec_q.push_back('{FN_AND,  32'hA5A5A5A5, 32'h0F0F0F0F, 33'h0_05050505, F_POS});
    vec_q.push_back('{FN_OR,   32'hA5A5A5A5, 32'h0F0F0F0F, 33'h0_AFAFAFAF, F_NEG});
    vec_q.push_back('{FN_XOR,  32'hA5A5A5A5, 32'h0F0F0F0F, 33'h0_AAAAAAAA, F_NEG});
    vec_q.push_back('{FN_NOR,  32'hA5A5A5A5, 32'h0F0F0F0F, 33'h0_50505050, F_POS});
    vec_q.push_back('{FN_PASSB,32'h11111111, 32'hDEADBEEF, 33'h0_DEADBEEF, F_NEG});
    vec_q.push_back('{FN_PASSB,32'hFFFFFFFF, 32'h00000000, 33'h0_00000000, F_ZERO});
    vec_q.push_back('{6'h3F,   32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0_00000000, F_ZERO});
    vec_q.push_back('{6'h21,   32'h00000002, 32'h00000001, 33'h0_00000000, F_ZERO});

    // Reset asserted from time 0: outputs cleared without any clock edge.
    rst_n = 1'b0;
    drive(FN_ADD, 32'd2, 32'd1);
    #2;
    check("reset_state", 33'h0, 5'b00000);

    // Release between edges: outputs hold 0 until the first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(FN_ADD, 32'd2, 32'd1);
    #1;
    check("hold_after_release", 33'h0, 5'b00000);
    @(posedge clk);
    #1;
    check("first_post_reset", 33'h0_00000003, F_POS);

    // Table vectors, one new operation every clock.
    foreach (vec_q[i]) begin
      @(negedge clk);
      drive(vec_q[i].funct, vec_q[i].a, vec_q[i].b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_fn%02h", i, vec_q[i].funct), vec_q[i].res, vec_q[i].flg);
    end

    // Mid-stream asynchronous reset clears a live result between edges.
    @(negedge clk);
    drive(FN_ADD, 32'd7, 32'd8);
    @(posedge clk);
    #1;
    check("pre_midreset", 33'h0_0000000F, F_POS);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_midreset", 33'h0, 5'b00000);

    // While held in reset, edges must not load the presented operation.
    @(negedge clk);
    drive(FN_OR, 32'hFFFF0000, 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("held_in_reset", 33'h0, 5'b00000);

    // First result after release comes from inputs at the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    drive(FN_SUB, 32'd9, 32'd4);
    #1;
    check("hold_after_midreset", 33'h0, 5'b00000);
    @(posedge clk);
    #1;
    check("first_after_midreset", 33'h0_00000005, F_POS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
